alu_flags_unit: RTL and testbench



---
 rtl/alu_flags_unit.sv | 153 +++++++++++++++
 tb/tb_alu_flags_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_flags_unit.sv
// NZCV condition-flag unit: computes flags from ALU operands/result, holds the
// architectural flag register, a sticky overflow bit and a saturating overflow counter.
module alu_flags_unit #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [WIDTH-1:0] resultado,
  input  logic [2:0]       ALU_Control,
  input  logic             set_flags,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             V_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  logic             s_valid;
  logic             s_set;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic [WIDTH-1:0] s_r;
  logic [2:0]       s_ctl;

  if (PIPE != 0) begin : g_pipe
    logic             p_valid_d, p_valid_q;
    logic             p_set_d, p_set_q;
    logic [WIDTH-1:0] p_a_d, p_a_q;
    logic [WIDTH-1:0] p_b_d, p_b_q;
    logic [WIDTH-1:0] p_r_d, p_r_q;
    logic [2:0]       p_ctl_d, p_ctl_q;

    always_comb begin
      p_valid_d = in_valid;
      p_set_d   = set_flags;
      p_a_d     = num1;
      p_b_d     = num2;
      p_r_d     = resultado;
      p_ctl_d   = ALU_Control;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_valid_q <= 1'b0;
        p_set_q   <= 1'b0;
        p_a_q     <= '0;
        p_b_q     <= '0;
        p_r_q     <= '0;
        p_ctl_q   <= '0;
      end else begin
        p_valid_q <= p_valid_d;
        p_set_q   <= p_set_d;
        p_a_q     <= p_a_d;
        p_b_q     <= p_b_d;
        p_r_q     <= p_r_d;
        p_ctl_q   <= p_ctl_d;
      end
    end

    assign s_valid = p_valid_q;
    assign s_set   = p_set_q;
    assign s_a     = p_a_q;
    assign s_b     = p_b_q;
    assign s_r     = p_r_q;
    assign s_ctl   = p_ctl_q;
  end else begin : g_comb
    assign s_valid = in_valid;
    assign s_set   = set_flags;
    assign s_a     = num1;
    assign s_b     = num2;
    assign s_r     = resultado;
    assign s_ctl   = ALU_Control;
  end

  logic             n_d, n_q, z_d, z_q, c_d, c_q, v_d, v_q;
  logic             sticky_d, sticky_q, out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_base;
  logic             is_arith, is_sub, wr, c_calc, v_calc, ovf_evt;
  logic [WIDTH-1:0] b_op, sum_lo_unused;

  always_comb begin
    is_arith = (s_ctl[2:1] == 2'b00);
    is_sub   = s_ctl[0];
    b_op     = is_sub ? ~s_b : s_b;
    // Carry-out of the WIDTH+1 bit sum; for sub this is the "no borrow" bit.
    {c_calc, sum_lo_unused} = {1'b0, s_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    if (is_sub)
      v_calc = (s_a[WIDTH-1] != s_b[WIDTH-1]) && (s_r[WIDTH-1] != s_a[WIDTH-1]);
    else
      v_calc = (s_a[WIDTH-1] == s_b[WIDTH-1]) && (s_r[WIDTH-1] != s_a[WIDTH-1]);
    wr      = s_valid && s_set;
    ovf_evt = wr && is_arith && v_calc;

    n_d = n_q;
    z_d = z_q;
    c_d = c_q;
    v_d = v_q;
    if (wr) begin
      n_d = s_r[WIDTH-1];
      z_d = (s_r == '0);
      if (is_arith) begin
        c_d = c_calc;
        v_d = v_calc;
      end
    end

    // Clear acts first, so a coincident overflow write still lands afterwards.
    sticky_d = clr_sticky ? ovf_evt : (sticky_q || ovf_evt);
    cnt_base = clr_sticky ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (ovf_evt && (cnt_base != '1))
      cnt_d = cnt_base + CNT_W'(1);

    out_valid_d = s_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;
  assign V_sticky  = sticky_q;
  assign ovf_count = cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_flags_unit.sv
// Self-checking bench: an 8-bit unpipelined instance with a 2-bit counter and a
// 32-bit pipelined instance, both checked against an arithmetic reference model.
module tb_alu_flags_unit;

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  ctl;
    logic        set;
    logic        clr;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0, s0, c0, ov0, n0, z0, cc0, vv0, st0;
  logic [7:0] a0, b0, r0;
  logic [2:0] ctl0;
  logic [1:0] cnt0;

  logic        v1, s1, c1, ov1, n1, z1, cc1, vv1, st1;
  logic [31:0] a1, b1, r1;
  logic [2:0]  ctl1;
  logic [7:0]  cnt1;

  alu_flags_unit #(.WIDTH(8), .PIPE(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .num1(a0), .num2(b0), .resultado(r0),
    .ALU_Control(ctl0), .set_flags(s0), .clr_sticky(c0), .out_valid(ov0),
    .N(n0), .Z(z0), .C(cc0), .V(vv0), .V_sticky(st0), .ovf_count(cnt0)
  );

  alu_flags_unit #(.WIDTH(32), .PIPE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .num1(a1), .num2(b1), .resultado(r1),
    .ALU_Control(ctl1), .set_flags(s1), .clr_sticky(c1), .out_valid(ov1),
    .N(n1), .Z(z1), .C(cc1), .V(vv1), .V_sticky(st1), .ovf_count(cnt1)
  );

  int checks = 0;
  int failures = 0;

  longint m_n[2], m_z[2], m_c[2], m_v[2], m_st[2], m_cnt[2], m_ov[2];
  op_t    pend1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(logic v, logic [31:0] a, logic [31:0] b, logic [31:0] r,
                             logic [2:0] ctl, logic s, logic c);
    op_t o;
    o.valid = v; o.a = a; o.b = b; o.r = r; o.ctl = ctl; o.set = s; o.clr = c;
    return o;
  endfunction

  function automatic longint sgn(longint x, int w);
    return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
  endfunction

  function automatic logic [31:0] pick(int w, logic [31:0] mask);
    logic [31:0] one = 32'd1;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return mask;
      2: return one << (w - 1);
      3: return (one << (w - 1)) - 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  function automatic op_t rnd(int w);
    op_t         o;
    logic [32:0] t = (33'd1 << w) - 33'd1;
    logic [31:0] mask = t[31:0];
    o.a   = pick(w, mask);
    o.b   = pick(w, mask);
    o.ctl = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) o.ctl[2:1] = 2'b00;
    if (o.ctl[2:1] == 2'b00)
      o.r = (o.ctl[0] ? o.a - o.b : o.a + o.b) & mask;
    else
      o.r = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & mask);
    o.valid = ($urandom_range(0, 3) != 0);
    o.set   = ($urandom_range(0, 3) != 0);
    o.clr   = ($urandom_range(0, 15) == 0);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_z[i] = 0; m_c[i] = 0; m_v[i] = 0;
      m_st[i] = 0; m_cnt[i] = 0; m_ov[i] = 0;
    end
    pend1 = mk(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Flags from the rules in plain integer arithmetic: carry is an unsigned range
  // test, overflow is a signed range test on the true result.
  task automatic model_apply(input int i, input op_t o, input logic clr, input int w,
                             input longint cmax);
    longint a, b, sres, lim;
    logic   ovf;
    ovf = 1'b0;
    a = longint'(o.a);
    b = longint'(o.b);
    if (o.valid && o.set) begin
      m_n[i] = (longint'(o.r) >> (w - 1)) & 1;
      m_z[i] = (o.r == 32'd0) ? 1 : 0;
      if (o.ctl[2:1] == 2'b00) begin
        if (o.ctl[0]) begin
          m_c[i] = (a >= b) ? 1 : 0;
          sres   = sgn(a, w) - sgn(b, w);
        end else begin
          m_c[i] = ((a + b) >= (longint'(1) << w)) ? 1 : 0;
          sres   = sgn(a, w) + sgn(b, w);
        end
        lim    = longint'(1) << (w - 1);
        ovf    = (sres >= lim) || (sres < -lim);
        m_v[i] = ovf ? 1 : 0;
      end
    end
    if (clr) begin
      m_st[i]  = ovf ? 1 : 0;
      m_cnt[i] = ovf ? 1 : 0;
    end else if (ovf) begin
      m_st[i] = 1;
      if (m_cnt[i] < cmax) m_cnt[i]++;
    end
  endtask

  task automatic drive(input op_t o0, input op_t o1);
    v0 = o0.valid; a0 = o0.a[7:0]; b0 = o0.b[7:0]; r0 = o0.r[7:0];
    ctl0 = o0.ctl; s0 = o0.set; c0 = o0.clr;
    v1 = o1.valid; a1 = o1.a; b1 = o1.b; r1 = o1.r;
    ctl1 = o1.ctl; s1 = o1.set; c1 = o1.clr;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov0"}, 64'(ov0), m_ov[0]);
    chk({tag, ".n0"}, 64'(n0), m_n[0]);
    chk({tag, ".z0"}, 64'(z0), m_z[0]);
    chk({tag, ".c0"}, 64'(cc0), m_c[0]);
    chk({tag, ".v0"}, 64'(vv0), m_v[0]);
    chk({tag, ".st0"}, 64'(st0), m_st[0]);
    chk({tag, ".cnt0"}, 64'(cnt0), m_cnt[0]);
    chk({tag, ".ov1"}, 64'(ov1), m_ov[1]);
    chk({tag, ".n1"}, 64'(n1), m_n[1]);
    chk({tag, ".z1"}, 64'(z1), m_z[1]);
    chk({tag, ".c1"}, 64'(cc1), m_c[1]);
    chk({tag, ".v1"}, 64'(vv1), m_v[1]);
    chk({tag, ".st1"}, 64'(st1), m_st[1]);
    chk({tag, ".cnt1"}, 64'(cnt1), m_cnt[1]);
  endtask

  // The pipelined instance's op lands one edge later; clr_sticky is taken live.
  task automatic step(input op_t o0, input op_t o1, input string tag);
    drive(o0, o1);
    @(posedge clk);
    model_apply(0, o0, o0.clr, 8, 3);
    m_ov[0] = o0.valid ? 1 : 0;
    model_apply(1, pend1, o1.clr, 32, 255);
    m_ov[1] = pend1.valid ? 1 : 0;
    pend1 = o1;
    #1;
    check_all(tag);
  endtask

  op_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    drive(idle, idle);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step(mk(1, 'h7F, 'h01, 'h80, 3'b000, 1, 0), idle, "add_ovf");
    step(mk(1, 'h00, 'h01, 'hFF, 3'b001, 1, 0), idle, "sub_borrow");
    step(mk(1, 'h80, 'h01, 'h7F, 3'b001, 1, 0), idle, "sub_ovf");
    step(mk(1, 'h00, 'h00, 'h00, 3'b010, 1, 0), idle, "logic_zero");
    step(mk(1, 'h00, 'h00, 'h80, 3'b010, 0, 0), idle, "logic_noset");
    step(mk(1, 'h05, 'h05, 'h00, 3'b001, 1, 0), idle, "sub_eq");
    step(mk(0, 'h7F, 'h01, 'h80, 3'b000, 1, 1), idle, "clr_only");
    repeat (5) step(mk(1, 'h7F, 'h01, 'h80, 3'b000, 1, 0), idle, "sat");
    step(mk(1, 'h7F, 'h01, 'h80, 3'b000, 1, 1), idle, "clr_and_ovf");

    step(idle, mk(1, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b000, 1, 0), "p_wrap");
    step(idle, mk(1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b000, 1, 0), "p_ovf");
    step(idle, mk(1, 32'h1, 32'h2, 32'hFFFF_FFFF, 3'b001, 1, 0), "p_sub");
    step(idle, mk(1, 32'h0, 32'h0, 32'h0000_1234, 3'b100, 1, 1), "p_logic_clr");
    step(idle, idle, "p_drain");
    step(idle, idle, "p_idle");

    repeat (400) step(rnd(8), rnd(32), "rand");

    step(mk(1, 'h7F, 'h01, 'h80, 3'b000, 1, 0),
         mk(1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b000, 1, 0), "pre_rst");
    drive(idle, idle);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(idle, idle, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
